// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command deframer: frame state encoding,
// command-byte field positions and per-field byte counts.
package uart_cmd_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADR,
        DAT,
        CHK
    } state_e;

    localparam int unsigned WR_BIT    = 7;
    localparam int unsigned CBE_LSB   = 0;
    localparam int unsigned CBE_W     = 4;
    localparam int unsigned ADR_BYTES = 4;
    localparam int unsigned DAT_BYTES = 4;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count sits at TOUT_CYC-1.
module uart_byte_timeout #(
    parameter int unsigned TOUT_CYC = 25000
) (
    input  logic clk,
    input  logic rst_,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned      CNT_W = (TOUT_CYC > 1) ? $clog2(TOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturate at the limit so a held-off expiry never wraps back to zero.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_deframer.sv
// Receive-side command deframer: assembles SYNC/CMD/ADR/DAT/CHK frames from the UART
// byte stream and holds each good frame as one address/data command for the bridge.
module uart_cmd_deframer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned TOUT_CYC  = 25000
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [3:0]  cmd_cbe,
    output logic [31:0] cmd_adr,
    output logic [31:0] cmd_data,
    output logic        err_chk,
    output logic        err_tout,
    output logic        err_ovf,
    output logic        busy
);

    state_e      r_state;
    logic [1:0]  r_idx;
    logic        r_write;
    logic [3:0]  r_cbe;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [7:0]  r_xor;

    logic        r_valid;
    logic        r_out_write;
    logic [3:0]  r_out_cbe;
    logic [31:0] r_out_adr;
    logic [31:0] r_out_dat;
    logic        r_err_chk;
    logic        r_err_tout;
    logic        r_err_ovf;

    logic        w_busy;
    logic        w_expire;
    logic        w_adr_last;
    logic        w_dat_last;

    assign w_busy     = (r_state != IDLE);
    assign w_adr_last = (r_idx == 2'(ADR_BYTES - 1));
    assign w_dat_last = (r_idx == 2'(DAT_BYTES - 1));

    uart_byte_timeout #(
        .TOUT_CYC (TOUT_CYC)
    ) u_tout (
        .clk      (clk),
        .rst_     (rst_),
        .i_clr    (rx_ready),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_cbe       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_xor       <= '0;
            r_valid     <= 1'b0;
            r_out_write <= 1'b0;
            r_out_cbe   <= '0;
            r_out_adr   <= '0;
            r_out_dat   <= '0;
            r_err_chk   <= 1'b0;
            r_err_tout  <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_err_chk  <= 1'b0;
            r_err_tout <= 1'b0;
            r_err_ovf  <= 1'b0;
            if (r_valid && cmd_ready) begin
                r_valid <= 1'b0;
            end
            if (rx_ready) begin
                unique case (r_state)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_state <= CMD;
                        end
                    end
                    CMD: begin
                        r_write <= rx_data[WR_BIT];
                        r_cbe   <= rx_data[CBE_LSB +: CBE_W];
                        r_xor   <= rx_data;
                        r_idx   <= '0;
                        r_state <= ADR;
                    end
                    ADR: begin
                        r_adr <= {r_adr[23:0], rx_data};
                        r_xor <= r_xor ^ rx_data;
                        r_idx <= r_idx + 2'd1;
                        if (w_adr_last) begin
                            r_idx   <= '0;
                            r_state <= r_write ? DAT : CHK;
                        end
                    end
                    DAT: begin
                        r_dat <= {r_dat[23:0], rx_data};
                        r_xor <= r_xor ^ rx_data;
                        r_idx <= r_idx + 2'd1;
                        if (w_dat_last) begin
                            r_idx   <= '0;
                            r_state <= CHK;
                        end
                    end
                    CHK: begin
                        r_state <= IDLE;
                        if (rx_data != r_xor) begin
                            r_err_chk <= 1'b1;
                        end else if (r_valid && !cmd_ready) begin
                            r_err_ovf <= 1'b1;
                        end else begin
                            // A slot freed by this cycle's handshake is refilled directly.
                            r_valid     <= 1'b1;
                            r_out_write <= r_write;
                            r_out_cbe   <= r_cbe;
                            r_out_adr   <= r_adr;
                            r_out_dat   <= r_write ? r_dat : '0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (w_expire) begin
                r_state    <= IDLE;
                r_err_tout <= 1'b1;
            end
        end
    end

    assign cmd_valid = r_valid;
    assign cmd_write = r_out_write;
    assign cmd_cbe   = r_out_cbe;
    assign cmd_adr   = r_out_adr;
    assign cmd_data  = r_out_dat;
    assign err_chk   = r_err_chk;
    assign err_tout  = r_err_tout;
    assign err_ovf   = r_err_ovf;
    assign busy      = w_busy;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed and randomized frame stimulus for uart_cmd_deframer, checked against a
// frame-level model of the held command slot.
module tb_uart_cmd_deframer;

    localparam int unsigned TOUT = 64;

    typedef struct {
        logic        wr;
        logic [3:0]  cbe;
        logic [31:0] adr;
        logic [31:0] dat;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_cbe;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_data;
    logic        err_chk;
    logic        err_tout;
    logic        err_ovf;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  frame[$];
    cmd_t        held_cmd;
    logic        held;

    always #5 clk = ~clk;

    uart_cmd_deframer #(
        .SYNC_BYTE (8'hA5),
        .TOUT_CYC  (TOUT)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_cbe   (cmd_cbe),
        .cmd_adr   (cmd_adr),
        .cmd_data  (cmd_data),
        .err_chk   (err_chk),
        .err_tout  (err_tout),
        .err_ovf   (err_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input cmd_t c);
        check({tag, ".write"}, 32'(cmd_write), 32'(c.wr));
        check({tag, ".cbe"}, 32'(cmd_cbe), 32'(c.cbe));
        check({tag, ".adr"}, cmd_adr, c.adr);
        check({tag, ".data"}, cmd_data, c.wr ? c.dat : 32'h0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 32'(cmd_valid), 32'h0);
        check({tag, ".write"}, 32'(cmd_write), 32'h0);
        check({tag, ".cbe"}, 32'(cmd_cbe), 32'h0);
        check({tag, ".adr"}, cmd_adr, 32'h0);
        check({tag, ".data"}, cmd_data, 32'h0);
        check({tag, ".errs"}, {29'h0, err_chk, err_tout, err_ovf}, 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input int unsigned gap_max);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i != frame.size() - 1) begin
                repeat ($urandom_range(0, gap_max)) tick();
            end
        end
    endtask

    // Frame = SYNC, CMD, ADR (MSB first), DAT for writes, XOR of everything after SYNC.
    task automatic build_frame(input cmd_t c, input logic [2:0] mid, input logic bad);
        logic [7:0] x;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back({c.wr, mid, c.cbe});
        for (int i = 3; i >= 0; i--) frame.push_back(c.adr[8*i +: 8]);
        if (c.wr) begin
            for (int i = 3; i >= 0; i--) frame.push_back(c.dat[8*i +: 8]);
        end
        x = 8'h00;
        for (int i = 1; i < frame.size(); i++) x = x ^ frame[i];
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr  = 1'($urandom);
        c.cbe = 4'($urandom);
        c.adr = $urandom;
        c.dat = c.wr ? $urandom : 32'h0;
        return c;
    endfunction

    initial begin
        cmd_t c1;
        cmd_t c2;
        logic bad;
        logic ready;
        logic held_before;
        logic [7:0] junk;

        rst_      = 1'b0;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        #3;
        check_idle_outputs("reset");
        tick();
        tick();
        rst_ = 1'b1;
        tick();

        // Directed write frame with the bridge always ready.
        cmd_ready = 1'b1;
        frame = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h10,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h98};
        send_frame(0);
        check("wr.valid", 32'(cmd_valid), 32'h1);
        c1 = '{wr: 1'b1, cbe: 4'h0, adr: 32'h0000_0010, dat: 32'h1234_5678};
        check_cmd("wr", c1);
        check("wr.errs", {29'h0, err_chk, err_tout, err_ovf}, 32'h0);
        tick();
        check("wr.valid_drop", 32'(cmd_valid), 32'h0);

        // Directed read frame.
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        send_frame(2);
        check("rd.valid", 32'(cmd_valid), 32'h1);
        c1 = '{wr: 1'b0, cbe: 4'h0, adr: 32'h0000_0020, dat: 32'h0};
        check_cmd("rd", c1);
        tick();

        // Checksum error.
        frame = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h10,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h99};
        send_frame(0);
        check("chk.err", 32'(err_chk), 32'h1);
        check("chk.valid", 32'(cmd_valid), 32'h0);
        tick();
        check("chk.pulse", 32'(err_chk), 32'h0);
        check("chk.busy", 32'(busy), 32'h0);

        // Inter-byte timeout after a partial frame.
        send_byte(8'hA5);
        send_byte(8'h80);
        send_byte(8'h00);
        check("tout.busy_pre", 32'(busy), 32'h1);
        repeat (TOUT - 1) tick();
        check("tout.early", 32'(err_tout), 32'h0);
        check("tout.busy_hold", 32'(busy), 32'h1);
        tick();
        check("tout.err", 32'(err_tout), 32'h1);
        check("tout.busy", 32'(busy), 32'h0);
        tick();
        check("tout.pulse", 32'(err_tout), 32'h0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        send_frame(1);
        check("tout.next_valid", 32'(cmd_valid), 32'h1);
        check("tout.next_adr", cmd_adr, 32'h0000_0020);
        tick();

        // Overflow: second frame arrives while the first is still held.
        cmd_ready = 1'b0;
        c1 = '{wr: 1'b1, cbe: 4'h3, adr: 32'h1000_0004, dat: 32'hCAFE_F00D};
        build_frame(c1, 3'h5, 1'b0);
        send_frame(0);
        check("ovf.valid1", 32'(cmd_valid), 32'h1);
        check_cmd("ovf.first", c1);
        c2 = '{wr: 1'b0, cbe: 4'hE, adr: 32'h2000_0008, dat: 32'h0};
        build_frame(c2, 3'h0, 1'b0);
        send_frame(0);
        check("ovf.err", 32'(err_ovf), 32'h1);
        check("ovf.valid2", 32'(cmd_valid), 32'h1);
        check_cmd("ovf.held", c1);
        tick();
        check("ovf.pulse", 32'(err_ovf), 32'h0);
        cmd_ready = 1'b1;
        tick();
        check("ovf.consumed", 32'(cmd_valid), 32'h0);

        // Reset in the middle of the address bytes while a command is held.
        cmd_ready = 1'b0;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        send_frame(0);
        check("rst.held", 32'(cmd_valid), 32'h1);
        send_byte(8'hA5);
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h00);
        #2;
        rst_ = 1'b0;
        #1;
        check_idle_outputs("rst.async");
        tick();
        tick();
        rst_      = 1'b1;
        cmd_ready = 1'b1;
        send_byte(8'h11);
        send_byte(8'h80);
        send_byte(8'h00);
        c1 = '{wr: 1'b1, cbe: 4'h9, adr: 32'hDEAD_BEE0, dat: 32'h0BAD_F00D};
        build_frame(c1, 3'h2, 1'b0);
        send_frame(1);
        check("rst.after_valid", 32'(cmd_valid), 32'h1);
        check_cmd("rst.after", c1);
        tick();

        // Randomized frames with random ready and occasional bad checksums.
        held = 1'b0;
        for (int n = 0; n < 30; n++) begin
            ready     = 1'($urandom);
            cmd_ready = ready;
            if (ready) held = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            c1  = rand_cmd();
            bad = ($urandom_range(0, 3) == 0);
            build_frame(c1, 3'($urandom), bad);
            send_frame(3);
            held_before = held;
            if (!bad && !held_before) begin
                held     = 1'b1;
                held_cmd = c1;
            end
            check("rnd.err_chk", 32'(err_chk), 32'(bad));
            check("rnd.err_ovf", 32'(err_ovf), 32'(!bad && held_before));
            check("rnd.err_tout", 32'(err_tout), 32'h0);
            check("rnd.busy", 32'(busy), 32'h0);
            check("rnd.valid", 32'(cmd_valid), 32'(held));
            if (held) check_cmd("rnd.cmd", held_cmd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_deframer.md
Name: uart_cmd_deframer

Overview:
Receive-side command framer between the UART byte receiver and the UART-to-PCI bridge.
- Assembles the serial byte stream into complete command frames: sync, command, address, optional data, XOR checksum.
- Checks each frame and presents it as one 32-bit address/data transaction on a valid/ready handshake.
- Frames that are malformed, stalled or arrive while the output slot is occupied are discarded and flagged with one-cycle error strobes.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TOUT_CYC, 25000, inter-byte timeout in clk cycles (1 ms at 25 MHz)

Ports:
clk  in  1  system clock (25 MHz domain)
rst_  in  1  reset; asynchronous, active-low
rx_ready  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
cmd_valid  out  1  assembled command held for bridge
cmd_ready  in  1  bridge accepts command this cycle
cmd_write  out  1  1 = write, 0 = read
cmd_cbe  out  4  PCI C/BE# byte enables, active-low
cmd_adr  out  32  transaction address
cmd_data  out  32  write data (0 for reads)
err_chk  out  1  pulse: checksum mismatch
err_tout  out  1  pulse: inter-byte timeout
err_ovf  out  1  pulse: frame dropped, output slot occupied
busy  out  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; holding register cleared.
- Reset asserted mid-frame or mid-handshake: frame discarded, cmd_valid drops asynchronously.
- Frame format, multi-byte fields MSB first:
  - SYNC, CMD, ADR[31:24..7:0], then DAT[31:24..7:0] for writes only, then CHK.
  - CMD[7] = write; CMD[3:0] = cbe; CMD[6:4] are ignored but included in the checksum.
  - CHK = XOR of all bytes after SYNC, excluding CHK itself.
- FSM transitions, taken only on rx_ready:
  - IDLE: byte == SYNC_BYTE -> CMD; any other byte is ignored with no error.
  - CMD: latch write and cbe; running xor <= byte; -> ADR with idx = 0.
  - ADR: shift the byte in; at idx == 3 go to DAT if write, else CHK.
  - DAT: shift the byte in; at idx == 3 -> CHK.
  - CHK: byte == running xor -> complete; otherwise err_chk pulse. Either way -> IDLE.
- Completion, evaluated the cycle after the CHK strobe:
  - Holding register empty, or cmd_ready = 1 in that same cycle: load the register; cmd_valid = 1.
  - Holding register full and cmd_ready = 0: new frame dropped, err_ovf pulse, held command untouched.
- Latency: cmd_valid rises exactly 1 clk after the rx_ready carrying CHK.
- Handshake:
  - cmd_valid stays high and cmd_* stay stable until a cycle with cmd_valid & cmd_ready.
  - cmd_valid falls the next cycle unless a frame completes in that same cycle; in that case it stays high with the new contents.
- Timeout:
  - Counter runs while state != IDLE and clears on every rx_ready.
  - Reaching TOUT_CYC-1 with no strobe that cycle -> IDLE, err_tout pulse, partial frame discarded.
  - rx_ready in the expiry cycle takes priority: the byte is processed and no timeout is signalled.
- A SYNC_BYTE value received mid-frame is treated as ordinary data; there is no resync.
- Error strobes last exactly one cycle. They are mutually exclusive per frame.

Decomposition:
- Package uart_cmd_pkg:
  - Default SYNC_BYTE.
  - State enum {IDLE, CMD, ADR, DAT, CHK}.
  - CMD bit positions (WR_BIT = 7, CBE_LSB = 0).
  - Field byte counts (ADR_BYTES = 4, DAT_BYTES = 4).
- One sub-module, uart_byte_timeout: parameterised counter with clear and enable inputs and an expire output; width $clog2(TOUT_CYC).

Test Plan:
- Write frame A5 80 00 00 00 10 12 34 56 78 98, cmd_ready held 1 -> one-cycle cmd_valid 1 clk after the last strobe; cmd_write = 1, cbe = 0, adr = 0x00000010, data = 0x12345678; no error strobes.
- Read frame A5 00 00 00 00 20 20 -> cmd_valid with cmd_write = 0, adr = 0x00000020, data = 0.
- Write frame with CHK = 0x99 instead of 0x98 -> err_chk single pulse, cmd_valid stays 0, busy = 0 afterwards.
- Send A5 80 00, then idle for TOUT_CYC cycles -> err_tout pulse, busy = 0. A following valid read frame is accepted normally.
- cmd_ready = 0: two back-to-back valid frames -> first held stable, second raises err_ovf. Then assert cmd_ready -> first frame consumed, cmd_valid = 0.
- Assert rst_ = 0 in the middle of the ADR bytes -> all outputs 0 immediately. After release, a fresh frame decodes correctly; bytes before its A5 are ignored.
